reg_cmd_sequencer: RTL
======================

# reg_cmd_sequencer

Command-driven initiator for the 4-bit multi-function register. It accepts operation commands over a valid/ready handshake and expands each command into a train of single-cycle control strobes: en with load data, inc, dec, shl or shr. It keeps a shadow copy of the value the register will hold, so upstream logic can read the result without a feedback path. It sits between the controller and the multi-function register and shares that register's clock and reset.

## Interface
- WIDTH, 4, data width of register and shadow
- CNT_W, 4, width of repeat count
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6/7 illegal
- cmd_data  in  WIDTH  load value; used only by LOAD
- cmd_count  in  CNT_W  number of strobes to issue (0..2^CNT_W-1)
- reg_in  out  WIDTH  data to the register's load input
- reg_en  out  1  load strobe
- reg_inc  out  1  increment strobe
- reg_dec  out  1  decrement strobe
- reg_shl  out  1  shift-left strobe
- reg_shr  out  1  shift-right strobe
- shadow  out  WIDTH  predicted register value
- busy  out  1  high in ISSUE and DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for an illegal op

## Operation
- FSM states: IDLE, ISSUE, DONE. All outputs are registered.
- IDLE behaviour:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op, data and count.
  - NOP, illegal op, or count==0 -> DONE.
  - Otherwise -> ISSUE, with remaining=count.
- ISSUE behaviour:
  - Exactly one strobe is high each cycle, selected by the latched op.
  - reg_in=latched data during LOAD; reg_in=0 otherwise.
  - Each ISSUE cycle, remaining decrements. remaining==1 at the cycle's closing edge -> DONE.
- DONE behaviour: done=1, and err=1 if the op was 6/7. Then -> IDLE.
- cmd_ready=0 in ISSUE and DONE. Commands presented then are held off, not dropped.
- Shadow updates on the edge that closes each strobe cycle, modulo 2^WIDTH:
  - LOAD: shadow=data.
  - INC: shadow+1, with 4'hF->0 wrap.
  - DEC: shadow-1, with 0->4'hF wrap.
  - SHL: logical shift left, zero fill, MSB lost.
  - SHR: logical shift right, zero fill.
- At most one of reg_en/inc/dec/shl/shr is high in any cycle, so the register's internal strobe ordering never matters.
- NOP, illegal op and count==0 issue no strobes and leave shadow unchanged.
- reset in any state: next edge gives IDLE; all strobes, reg_in, done, err and busy = 0; shadow=0 (matches the register's reset value); latched command discarded.

## Timing
- Command accepted at edge k with count N>0:
  - Strobes high in cycles k+1..k+N.
  - done high in cycle k+N+1.
  - cmd_ready high again from cycle k+N+2.
- count==0, NOP or illegal op: done (and err if applicable) in cycle k+1; cmd_ready returns at k+2.
- Throughput: one command per N+2 cycles.
- shadow equals the register's value in every cycle, given that both share clk/reset and the register is driven only by this block.
- cmd_valid may drop while cmd_ready=0 without effect. The payload is sampled only on the accept edge.
- Reset values: cmd_ready=1, busy=0, done=0, err=0, shadow=0, reg_in=0, all strobes 0.

## Test plan
- Reset then LOAD data=9 count=1 -> reg_en high 1 cycle with reg_in=9; shadow=9; done next cycle; no other strobe.
- shadow=14, INC count=3 -> reg_inc high 3 consecutive cycles; shadow 15, 0, 1; done after; mirror register reads 1.
- shadow=4'b0111, SHL count=2 -> shadow 4'b1110 then 4'b1100. Then DEC count=1 from 0 after reset -> shadow 4'hF.
- INC count=0 -> no strobes; done at k+1; shadow unchanged; cmd_ready back at k+2. Op=6 count=5 -> done and err together; no strobes.
- Reset asserted in the 2nd cycle of a DEC count=5 -> strobes drop next edge; shadow=0; cmd_ready=1; no done pulse. A new LOAD 3 then completes normally.
- cmd_valid held high back-to-back: INC 2 then SHR 1 -> second command accepted only when cmd_ready is high. Strobe sequence inc, inc, (done), -, shr; shadow tracks the mirror register every cycle.

Source files
------------

// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer: command-driven initiator for a multi-function register.
// Accepts one command per valid/ready handshake and expands it into a train of
// single-cycle strobes (load/inc/dec/shl/shr). It keeps a shadow copy of the
// value the register will hold, so upstream logic can read it without feedback.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o handshake; cmd_op_i, cmd_data_i, cmd_count_i payload
//   reg_in_o, reg_en_o, reg_inc_o, reg_dec_o, reg_shl_o, reg_shr_o  register controls
//   shadow_o                  predicted register value
//   busy_o, done_o, err_o     status; done/err are one-cycle pulses
module reg_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  output logic [WIDTH-1:0] reg_in_o,
  output logic             reg_en_o,
  output logic             reg_inc_o,
  output logic             reg_dec_o,
  output logic             reg_shl_o,
  output logic             reg_shr_o,
  output logic [WIDTH-1:0] shadow_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpLoad = 3'd1;
  localparam logic [2:0] OpInc  = 3'd2;
  localparam logic [2:0] OpDec  = 3'd3;
  localparam logic [2:0] OpShl  = 3'd4;
  localparam logic [2:0] OpShr  = 3'd5;

  // Strobe vector order: {shr, shl, dec, inc, en}.
  function automatic logic [4:0] op_strobe(input logic [2:0] op);
    logic [4:0] s;
    s = 5'b00000;
    case (op)
      OpLoad:  s = 5'b00001;
      OpInc:   s = 5'b00010;
      OpDec:   s = 5'b00100;
      OpShl:   s = 5'b01000;
      OpShr:   s = 5'b10000;
      default: s = 5'b00000;
    endcase
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [4:0]       strb_q, strb_d;
  logic [WIDTH-1:0] reg_in_q, reg_in_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cmd_illegal;
  logic             cmd_no_strobe;

  assign cmd_illegal   = (cmd_op_i > OpShr);
  assign cmd_no_strobe = (cmd_op_i == OpNop) || cmd_illegal || (cmd_count_i == '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    rem_d    = rem_q;
    shadow_d = shadow_q;
    strb_d   = 5'b00000;
    reg_in_d = '0;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          op_d   = cmd_op_i;
          data_d = cmd_data_i;
          rem_d  = cmd_count_i;
          busy_d = 1'b1;
          if (cmd_no_strobe) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = cmd_illegal;
          end else begin
            state_d  = StIssue;
            strb_d   = op_strobe(cmd_op_i);
            reg_in_d = (cmd_op_i == OpLoad) ? cmd_data_i : '0;
          end
        end else begin
          ready_d = 1'b1;
        end
      end

      StIssue: begin
        // The strobe currently on the outputs takes effect at this edge.
        case (op_q)
          OpLoad:  shadow_d = data_q;
          OpInc:   shadow_d = shadow_q + 1'b1;
          OpDec:   shadow_d = shadow_q - 1'b1;
          OpShl:   shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
          OpShr:   shadow_d = {1'b0, shadow_q[WIDTH-1:1]};
          default: shadow_d = shadow_q;
        endcase
        rem_d  = rem_q - 1'b1;
        busy_d = 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          strb_d   = op_strobe(op_q);
          reg_in_d = (op_q == OpLoad) ? data_q : '0;
        end
      end

      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      op_q     <= OpNop;
      data_q   <= '0;
      rem_q    <= '0;
      shadow_q <= '0;
      strb_q   <= 5'b00000;
      reg_in_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      shadow_q <= shadow_d;
      strb_q   <= strb_d;
      reg_in_q <= reg_in_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign reg_in_o    = reg_in_q;
  assign reg_en_o    = strb_q[0];
  assign reg_inc_o   = strb_q[1];
  assign reg_dec_o   = strb_q[2];
  assign reg_shl_o   = strb_q[3];
  assign reg_shr_o   = strb_q[4];
  assign shadow_o    = shadow_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
